// File: rtl/fir_stream_ctrl.sv
// fir_stream_ctrl: Wishbone sequencer for the FIR engine's AXI-Stream ports.
// Buffers X/Y samples, generates tlast, flags completion, times each run.
module fir_stream_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= din;
  end

  assign dout  = mem[rp[AW-1:0]];
  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) &&
                 (wp[AW-1:0] == rp[AW-1:0]);
endmodule

module fir_stream_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 16
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [7:0]        wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              ss_tvalid,
  output logic [DATA_W-1:0] ss_tdata,
  output logic              ss_tlast,
  input  logic              ss_tready,
  input  logic              sm_tvalid,
  input  logic [DATA_W-1:0] sm_tdata,
  input  logic              sm_tlast,
  output logic              sm_tready,
  output logic              fir_start
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [5:0] A_CTRL = 6'h00;
  localparam logic [5:0] A_LEN  = 6'h01;
  localparam logic [5:0] A_STAT = 6'h02;
  localparam logic [5:0] A_CYC  = 6'h03;
  localparam logic [5:0] A_X    = 6'h20;
  localparam logic [5:0] A_Y    = 6'h21;

  state_t            state, state_nx;
  logic [LEN_W-1:0]  len_q, x_cnt, y_cnt, cyc_q;
  logic              done_q, err_q, start_q;
  logic              x_full, x_empty, y_full, y_empty;
  logic [DATA_W-1:0] x_dout, y_dout;
  logic              sel, ready, acc, ss_hs, sm_hs;
  logic              x_push, y_pop, last_y, start_ok;
  logic              running;
  logic [5:0]        word;
  logic [31:0]       rdata;
  logic              unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];
  assign word       = wbs_adr_i[7:2];
  assign running    = (state == RUN);

  // ack is never high back to back, so a held strobe cannot double-commit
  assign sel   = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign ss_hs = ss_tvalid & ss_tready;
  assign sm_hs = sm_tvalid & sm_tready;

  always_comb begin
    ready = 1'b1;
    if (wbs_we_i && word == A_X)
      ready = ~x_full | ss_hs;
    if (!wbs_we_i && word == A_Y)
      ready = ~y_empty;
  end

  assign acc      = sel & ready;
  assign x_push   = acc & wbs_we_i & (word == A_X);
  assign y_pop    = acc & ~wbs_we_i & (word == A_Y);
  assign start_ok = acc & wbs_we_i & (word == A_CTRL) &
                    wbs_dat_i[0] & (|len_q) & ~running;
  assign last_y   = sm_hs & (y_cnt == len_q - LEN_W'(1));

  assign ss_tvalid = running & ~x_empty & (x_cnt < len_q);
  assign ss_tlast  = running & (x_cnt == len_q - LEN_W'(1));
  assign ss_tdata  = x_dout;
  assign sm_tready = running & ~y_full;

  fir_stream_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_xq (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (x_push),
    .pop   (ss_hs),
    .din   (wbs_dat_i[DATA_W-1:0]),
    .dout  (x_dout),
    .full  (x_full),
    .empty (x_empty)
  );

  fir_stream_fifo #(.W(DATA_W), .DEPTH(DEPTH)) u_yq (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (sm_hs),
    .pop   (y_pop),
    .din   (sm_tdata),
    .dout  (y_dout),
    .full  (y_full),
    .empty (y_empty)
  );

  always_comb begin
    rdata = '0;
    unique case (word)
      A_CTRL: rdata = {29'b0, ~running, done_q, running};
      A_LEN:  rdata = 32'(len_q);
      A_STAT: rdata = {27'b0, err_q, y_empty, y_full,
                       x_empty, x_full};
      A_CYC:  rdata = 32'(cyc_q);
      A_Y:    rdata = 32'(y_dout);
      default: rdata = '0;
    endcase
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start_q) state_nx = RUN;
      RUN:        if (last_y)  state_nx = DONE;
      default:    state_nx = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      start_q   <= 1'b0;
      fir_start <= 1'b0;
      len_q     <= '0;
      x_cnt     <= '0;
      y_cnt     <= '0;
      cyc_q     <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      wbs_ack_o <= acc;
      wbs_dat_o <= (acc & ~wbs_we_i) ? rdata : '0;
      start_q   <= start_ok;
      fir_start <= start_q;
      if (acc && wbs_we_i && word == A_LEN && !running)
        len_q <= wbs_dat_i[LEN_W-1:0];
      if (acc && !wbs_we_i && word == A_CTRL)
        done_q <= 1'b0;
      // a completion on the same edge as a CTRL read must win
      if (start_q) begin
        x_cnt  <= '0;
        y_cnt  <= '0;
        cyc_q  <= '0;
        err_q  <= 1'b0;
        done_q <= 1'b0;
      end else if (running) begin
        if (ss_hs) x_cnt <= x_cnt + LEN_W'(1);
        if (sm_hs) y_cnt <= y_cnt + LEN_W'(1);
        if (~&cyc_q) cyc_q <= cyc_q + LEN_W'(1);
        if (sm_hs && sm_tlast && !last_y) err_q <= 1'b1;
        if (last_y) done_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_fir_stream_ctrl.sv
// tb_fir_stream_ctrl: Wishbone firmware driver, FIR stream model and
// Y-data scoreboard around fir_stream_ctrl.
module tb_fir_stream_ctrl;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [7:0]    adr = '0;
  logic [31:0]   dat_i = '0;
  logic [31:0]   dat_o;
  logic          ack;
  logic          ss_tvalid, ss_tlast;
  logic          ss_tready = 1'b0;
  logic [DW-1:0] ss_tdata;
  logic          sm_tvalid = 1'b0, sm_tlast = 1'b0;
  logic          sm_tready;
  logic [DW-1:0] sm_tdata = '0;
  logic          fir_start;

  int          errors = 0, checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mdl_q[$];
  int          x_idx = 0, y_idx = 0, run_len = 0, tlast_at = -1;
  int          ss_limit = 1000, run_cyc = 0, fs_count = 0;
  bit          ss_en = 1'b1, rand_mode = 1'b0;
  bit          counting = 1'b0, prev_hs = 1'b0, saw_bp = 1'b0;
  longint      t_ss = 0, t_ack = 0;

  fir_stream_ctrl dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbs_cyc_i (cyc),
    .wbs_stb_i (stb),
    .wbs_we_i  (we),
    .wbs_adr_i (adr),
    .wbs_dat_i (dat_i),
    .wbs_dat_o (dat_o),
    .wbs_ack_o (ack),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .ss_tready (ss_tready),
    .sm_tvalid (sm_tvalid),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast),
    .sm_tready (sm_tready),
    .fir_start (fir_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fir_f(input logic [31:0] x);
    return x * 32'd3 + 32'd1;
  endfunction

  // FIR model: drives stream inputs 1 unit after negedge, predicts handshakes
  always @(negedge clk) begin
    #1;
    if (rst) begin
      ss_tready = 1'b0;
      sm_tvalid = 1'b0;
      sm_tlast  = 1'b0;
      mdl_q.delete();
      counting  = 1'b0;
      prev_hs   = 1'b0;
    end else begin
      if (fir_start) begin
        fs_count++;
        x_idx    = 0;
        y_idx    = 0;
        run_cyc  = 0;
        counting = 1'b1;
      end
      if (counting) run_cyc++;
      if (!(sm_tvalid && !prev_hs)) begin
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        if (mdl_q.size() > 0 &&
            (!rand_mode || $urandom_range(1) == 1)) begin
          sm_tvalid = 1'b1;
          sm_tdata  = mdl_q[0];
          sm_tlast  = (y_idx == tlast_at);
        end
      end
      ss_tready = ss_en && (x_idx < ss_limit) &&
                  (!rand_mode || $urandom_range(1) == 1);
      if (sm_tvalid && !sm_tready) saw_bp = 1'b1;
      prev_hs = sm_tvalid && sm_tready;
      if (ss_tvalid && ss_tready) begin
        check("ss_tlast", 32'(ss_tlast),
              32'(x_idx == run_len - 1));
        if (x_idx == 0) t_ss = $time;
        mdl_q.push_back(fir_f(ss_tdata));
        x_idx++;
      end
      if (prev_hs) begin
        void'(mdl_q.pop_front());
        y_idx++;
        if (y_idx == run_len) counting = 1'b0;
      end
    end
  end

  task automatic wb_xfer(input logic w, input logic [7:0] a,
                         input logic [31:0] d,
                         output logic [31:0] q);
    int n = 0;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat_i = d;
    q = 'x;
    do begin
      @(negedge clk);
      n++;
    end while (!ack && n < 500);
    check("wb_ack", 32'(ack), 32'd1);
    if (ack) q = dat_o;
    t_ack = $time;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wb_wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] q;
    wb_xfer(1'b1, a, d, q);
  endtask

  task automatic wb_rd(input logic [7:0] a, output logic [31:0] q);
    wb_xfer(1'b0, a, 32'd0, q);
  endtask

  task automatic x_push(input logic [31:0] d);
    exp_q.push_back(fir_f(d));
    wb_wr(8'h80, d);
  endtask

  task automatic read_y();
    logic [31:0] q;
    logic [31:0] e;
    e = 'x;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    wb_rd(8'h84, q);
    check("y_data", q, e);
  endtask

  task automatic chk_reset_outs(input string pfx);
    check({pfx, "_ack"}, 32'(ack), 32'd0);
    check({pfx, "_dat"}, dat_o, 32'd0);
    check({pfx, "_ss_tvalid"}, 32'(ss_tvalid), 32'd0);
    check({pfx, "_ss_tlast"}, 32'(ss_tlast), 32'd0);
    check({pfx, "_sm_tready"}, 32'(sm_tready), 32'd0);
    check({pfx, "_fir_start"}, 32'(fir_start), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int fs0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_outs("rst");
    wb_rd(8'h00, d); check("ctrl_reset", d, 32'h4);
    wb_rd(8'h08, d); check("status_reset", d, 32'hA);
    wb_rd(8'h0C, d); check("cycles_reset", d, 32'h0);
    check("no_start_reset", 32'(fs_count), 32'd0);

    // LEN=11, prefilled X FIFO, stalled X write, slow Y reads
    ss_en = 1'b0; run_len = 11; tlast_at = 10; saw_bp = 1'b0;
    wb_wr(8'h04, 32'd11);
    wb_rd(8'h04, d); check("len_rb", d, 32'd11);
    for (int i = 0; i < 4; i++) x_push(32'h100 + i);
    wb_rd(8'h08, d); check("status_xfull", d, 32'h9);
    wb_wr(8'h00, 32'd1);
    fork
      x_push(32'h104);
      begin
        repeat (10) @(negedge clk);
        ss_en = 1'b1;
      end
    join
    check("x_stall_ack", 32'(t_ack - t_ss), 32'd9);
    for (int i = 5; i < 11; i++) x_push(32'h100 + i);
    repeat (20) @(negedge clk);
    wb_rd(8'h08, d); check("status_yfull", d, 32'h6);
    for (int i = 0; i < 11; i++) begin
      if (i > 0) repeat (20) @(negedge clk);
      read_y();
    end
    check("y_backpressure", 32'(saw_bp), 32'd1);
    wb_rd(8'h00, d); check("ctrl_done", d, 32'h6);
    wb_rd(8'h00, d); check("ctrl_done_clr", d, 32'h4);
    check("start_pulses", 32'(fs_count), 32'd1);

    // random duty, start during RUN must be ignored
    rand_mode = 1'b1; run_len = 8; tlast_at = 7; fs0 = fs_count;
    wb_wr(8'h04, 32'd8);
    wb_wr(8'h00, 32'd1);
    for (int i = 0; i < 3; i++) x_push(32'h200 + i * 7);
    wb_wr(8'h00, 32'd1);
    for (int i = 3; i < 8; i++) x_push(32'h200 + i * 7);
    for (int i = 0; i < 8; i++) read_y();
    rand_mode = 1'b0;
    wb_rd(8'h00, d); check("ctrl_done_rand", d, 32'h6);
    wb_rd(8'h0C, d); check("cycles", d, 32'(run_cyc));
    check("start_in_run", 32'(fs_count - fs0), 32'd1);

    // LEN=0 start ignored
    fs0 = fs_count;
    wb_wr(8'h04, 32'd0);
    wb_wr(8'h00, 32'd1);
    repeat (5) @(negedge clk);
    check("len0_no_start", 32'(fs_count - fs0), 32'd0);
    wb_rd(8'h00, d); check("len0_idle", d, 32'h4);

    // early sm_tlast on output 3 of 5
    run_len = 5; tlast_at = 2;
    wb_wr(8'h04, 32'd5);
    wb_wr(8'h00, 32'd1);
    for (int i = 0; i < 5; i++) x_push(32'h300 + i);
    for (int i = 0; i < 5; i++) read_y();
    wb_rd(8'h00, d); check("ctrl_done_err", d, 32'h6);
    wb_rd(8'h08, d); check("status_tlast_err", d, 32'h1A);

    // reset after 3 samples of a LEN=6 run
    run_len = 6; tlast_at = 5; ss_limit = 3;
    wb_wr(8'h04, 32'd6);
    wb_wr(8'h00, 32'd1);
    for (int i = 0; i < 6; i++) x_push(32'h400 + i);
    for (int i = 0; i < 200 && x_idx < 3; i++) @(negedge clk);
    check("pre_rst_samples", 32'(x_idx), 32'd3);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_reset_outs("midrst");
    rst = 1'b0;
    exp_q.delete();
    ss_limit = 1000;
    wb_rd(8'h08, d); check("status_post_rst", d, 32'hA);
    wb_rd(8'h00, d); check("ctrl_post_rst", d, 32'h4);

    // LEN=2 run after reset
    run_len = 2; tlast_at = 1;
    wb_wr(8'h04, 32'd2);
    wb_wr(8'h00, 32'd1);
    x_push(32'h500);
    x_push(32'h501);
    read_y();
    read_y();
    wb_rd(8'h00, d); check("ctrl_done_len2", d, 32'h6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fir_stream_ctrl.md
# fir_stream_ctrl

Sequencer between the Caravel Wishbone user-project bus and the FIR engine's AXI-Stream ports. Firmware programs a transfer length, starts a run, pushes input samples through a write-only window and pops results through a read-only window. The block buffers both streams, generates `tlast`, detects completion and measures run latency in clock cycles. It replaces firmware polling of raw AXI-Stream handshakes and sits inside `user_project_wrapper` next to the FIR.

## Interface
Parameters:
- `DATA_W`, default 32: stream sample width.
- `DEPTH`, default 4: X and Y FIFO depth, power of 2.
- `LEN_W`, default 16: width of the length register and the counters.

Ports:
- `wb_clk_i`  in  1: single clock.
- `wb_rst_i`  in  1: reset, synchronous, active-high.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each: Wishbone strobes. The block is selected when `cyc & stb`.
- `wbs_adr_i`  in  8: byte offset. Bits [1:0] are ignored.
- `wbs_dat_i`  in  32: write data. `wbs_sel_i` is not used; all writes are full-word.
- `wbs_dat_o`  out  32: read data.
- `wbs_ack_o`  out  1: one-cycle acknowledge.
- `ss_tvalid`  out  1, `ss_tdata`  out  DATA_W, `ss_tlast`  out  1, `ss_tready`  in  1: X stream to the FIR.
- `sm_tvalid`  in  1, `sm_tdata`  in  DATA_W, `sm_tlast`  in  1, `sm_tready`  out  1: Y stream from the FIR.
- `fir_start`  out  1: one-cycle pulse at the beginning of a run.

## Operation
Register map (offsets):
- 0x00 CTRL
  - Write: bit0=1 requests a start.
  - Read: bit0 = running, bit1 = done, bit2 = idle.
  - A read of CTRL clears done.
- 0x04 LEN: R/W, LEN_W bits. Writes are ignored while running.
- 0x08 STATUS (RO):
  - bit0 x_full, bit1 x_empty, bit2 y_full, bit3 y_empty.
  - bit4 tlast_err: sticky; cleared by the next start.
- 0x0C CYCLES (RO): latency of the last run.
- 0x80 X (WO): pushes `wbs_dat_i` into the X FIFO.
- 0x84 Y (RO): pops the Y FIFO head.
- Unmapped offsets: reads return 0; writes are acknowledged and dropped.

State machine IDLE, RUN, DONE:
- IDLE → RUN, or DONE → RUN: on a CTRL start write when LEN≠0.
  - Clears `x_cnt`, `y_cnt`, CYCLES and tlast_err.
  - Pulses `fir_start`.
  - A start with LEN=0 is ignored; the state does not change.
- RUN:
  - `ss_tvalid` = X FIFO not empty and `x_cnt` < LEN.
  - `ss_tlast` = (`x_cnt` == LEN-1).
  - An `ss` handshake pops the X FIFO and increments `x_cnt`.
  - `sm_tready` = Y FIFO not full. An `sm` handshake pushes the Y FIFO and increments `y_cnt`.
  - An `sm_tlast` that does not coincide with the LEN-th output sets tlast_err.
  - CYCLES increments every RUN cycle, saturating at all-ones.
- RUN → DONE: on the cycle in which the LEN-th Y handshake occurs.
- DONE: Y FIFO contents remain readable. A start write in RUN is ignored.
- Outside RUN: `ss_tvalid`=0 and `sm_tready`=0.
- X writes are accepted in any state, so firmware may pre-fill before start.
- The X FIFO is not flushed on start. Y FIFO and X FIFO are flushed only by reset.

## Timing
- Reset values:
  - State IDLE.
  - All counters, registers and FIFO pointers 0.
  - `wbs_ack_o`=0, `wbs_dat_o`=0.
  - `ss_tvalid`=0, `ss_tlast`=0, `sm_tready`=0, `fir_start`=0.
- Reset asserted mid-run aborts immediately. No further stream handshakes occur from the next edge.
- Wishbone:
  - `ack` is registered and asserts 1 cycle after `cyc&stb` rises. `ack` is never high two consecutive cycles.
  - Read data is valid with `ack`.
- Backpressure:
  - An X write while the X FIFO is full holds `ack` low until a slot frees. The push and the `ack` happen in the same cycle.
  - A Y read while the Y FIFO is empty holds `ack` low until data arrives.
- FIFOs:
  - Push and pop in the same cycle are allowed at any fill level except: a push to a full FIFO is permitted only with a simultaneous pop.
  - Zero bubble: `ss_tvalid` is high the cycle after a write to the empty X FIFO.
- `fir_start` is high exactly the cycle after the start write is acknowledged. CYCLES counts from that cycle.
- `done` sets in the same edge as RUN → DONE. `done` is visible on the CTRL read issued the next cycle.

## Test plan
- Reset, then read CTRL → 0x4 (idle). STATUS → 0xA. `fir_start`=0 and `ss_tvalid`=0 throughout.
- LEN=11, prefill 4 X (FIFO full), then start. Fifth X write stalls `ack` until the first `ss` handshake. `ss_tlast` is set only on sample 11.
- FIR model returns 11 Y values with `sm_tready` honoured and Y reads delayed 20 cycles each. The Y FIFO fills to 4, `sm_tready` drops, and no data is lost. CTRL → 0x6 after the 11th handshake; a second CTRL read → 0x4.
- Run with an `ss_tready`/`sm_tvalid` random 50% duty. CYCLES equals the bench-counted RUN cycles. A start during RUN leaves `x_cnt` unchanged.
- LEN=0 then start → no `fir_start`, state stays IDLE. Model asserts `sm_tlast` on output 3 with LEN=5 → STATUS bit4=1, and the run still completes at 5.
- Assert `wb_rst_i` mid-run after 3 samples → all outputs return to reset values at the next edge. A following LEN=2 run completes normally.
